// File: rtl/gslcd_fetch_scheduler.sv
// gslcd_fetch_scheduler
// Framebuffer fetch scheduler for the gslcd LCD path. Walks the framebuffer
// from a programmed base with fixed-length AXI read bursts on the AR channel.
// A burst is issued only when the pixel FIFO has credit for all of it, and
// the number of bursts still awaiting RLAST is capped.
// Optional feature macro: GSLCD_FETCH_DBUF_EN (double-buffered base with a
// swap request / acknowledge handshake applied at the start of a frame).
module gslcd_fetch_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int BURST_LEN       = 16,
  parameter int FIFO_DEPTH      = 512,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FRAME_BURSTS    = 1500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] fb_base,
  input  logic                  frame_start,
  input  logic                  fifo_pop,
  output logic                  fifo_flush,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic                  r_last_done,
`ifdef GSLCD_FETCH_DBUF_EN
  output logic                  swap_ack,
  input  logic [ADDR_WIDTH-1:0] fb_base_next,
  input  logic                  swap_req,
`endif
  output logic                  busy
);

  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BL_W   = $clog2(FRAME_BURSTS + 1);

  localparam logic [CRED_W-1:0]     CRED_FULL    = CRED_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0]     CRED_BURST   = CRED_W'(BURST_LEN);
  localparam logic [CRED_W-1:0]     CRED_ZERO    = {CRED_W{1'b0}};
  localparam logic [OUT_W-1:0]      OUT_MAX      = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]      OUT_ZERO     = {OUT_W{1'b0}};
  localparam logic [BL_W-1:0]       BURSTS_FRAME = BL_W'(FRAME_BURSTS);
  localparam logic [BL_W-1:0]       BL_ZERO      = {BL_W{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO    = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP    = ADDR_WIDTH'(BURST_LEN * 4);
  // Bursts are aligned to their own size so they never cross a 4 KB page.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK    = ~(ADDR_STEP - ADDR_ONE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_FLUSH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [BL_W-1:0]       bursts_left_q, bursts_left_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  en_q, en_d;
  logic                  restart_q, restart_d;
  logic                  arvalid_q, arvalid_d;
  logic                  flush_q, flush_d;
  logic                  busy_q, busy_d;

  logic                  ar_hs;
  logic                  pop_ok;
  logic                  rlast_ok;
  logic                  en_eff;
  logic [ADDR_WIDTH-1:0] base_sel;

`ifdef GSLCD_FETCH_DBUF_EN
  logic                  swap_pend_q, swap_pend_d;
  logic                  swap_ack_q, swap_ack_d;

  // The swap decision is taken on entry to FLUSH, so the flag is already
  // registered while the base is being loaded.
  assign base_sel = swap_ack_q ? fb_base_next : fb_base;
  assign swap_ack = swap_ack_q;
`else
  assign base_sel = fb_base;
`endif

  assign ar_hs      = arvalid_q & m_arready;
  assign en_eff     = frame_start ? enable : en_q;
  assign m_arlen    = 8'(BURST_LEN - 1);
  assign m_arvalid  = arvalid_q;
  assign m_araddr   = addr_q;
  assign fifo_flush = flush_q;
  assign busy       = busy_q;

  // Credit, outstanding, burst-count and address bookkeeping
  always_comb begin
    pop_ok        = fifo_pop & (credits_q != CRED_FULL);
    rlast_ok      = r_last_done & (outstanding_q != OUT_ZERO);
    outstanding_d = outstanding_q + OUT_W'(ar_hs) - OUT_W'(rlast_ok);
    if (state_q == ST_FLUSH) begin
      // New frame: FIFO is empty again, pops this cycle belong to the old frame.
      credits_d     = CRED_FULL;
      bursts_left_d = BURSTS_FRAME;
      addr_d        = base_sel & ADDR_MASK;
    end else begin
      credits_d     = credits_q + CRED_W'(pop_ok) - (ar_hs ? CRED_BURST : CRED_ZERO);
      bursts_left_d = bursts_left_q - BL_W'(ar_hs);
      addr_d        = ar_hs ? (addr_q + ADDR_STEP) : addr_q;
    end
  end

  // Next-state decision and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    restart_d = 1'b0;
    if (frame_start) begin
      en_d = enable;
    end else begin
      en_d = en_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == OUT_ZERO) begin
          state_d = en_eff ? ST_FLUSH : ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        state_d   = ST_ISSUE;
        restart_d = frame_start;
      end
      ST_ISSUE: begin
        // The request stays up until accepted; a new frame waits for that.
        if (ar_hs) begin
          state_d   = (restart_q | frame_start) ? ST_DRAIN : ST_WAIT;
          restart_d = 1'b0;
        end else begin
          state_d   = ST_ISSUE;
          restart_d = restart_q | frame_start;
        end
      end
      ST_WAIT: begin
        if (frame_start) begin
          state_d = ST_DRAIN;
        end else if (bursts_left_q == BL_ZERO) begin
          state_d = ST_IDLE;
        end else if ((credits_q >= CRED_BURST) && (outstanding_q < OUT_MAX)) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    arvalid_d = (state_d == ST_ISSUE);
    flush_d   = (state_d == ST_FLUSH);
    busy_d    = (state_d != ST_IDLE);

`ifdef GSLCD_FETCH_DBUF_EN
    swap_ack_d  = flush_d & swap_pend_q;
    swap_pend_d = swap_req | (swap_pend_q & ~flush_d);
`endif
  end

  // State register, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credits_q     <= CRED_FULL;
      outstanding_q <= OUT_ZERO;
      bursts_left_q <= BL_ZERO;
      addr_q        <= ADDR_ZERO;
      en_q          <= 1'b0;
      restart_q     <= 1'b0;
      arvalid_q     <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
`ifdef GSLCD_FETCH_DBUF_EN
      swap_pend_q   <= 1'b0;
      swap_ack_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      bursts_left_q <= bursts_left_d;
      addr_q        <= addr_d;
      en_q          <= en_d;
      restart_q     <= restart_d;
      arvalid_q     <= arvalid_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
`ifdef GSLCD_FETCH_DBUF_EN
      swap_pend_q   <= swap_pend_d;
      swap_ack_q    <= swap_ack_d;
`endif
    end
  end

endmodule

// File: tb/tb_gslcd_fetch_scheduler.sv
// Testbench for gslcd_fetch_scheduler: directed steps plus a randomized phase,
// checked against a transaction-level model of credits, outstanding bursts
// and the expected burst address sequence.
module tb_gslcd_fetch_scheduler;

  localparam int          BL    = 16;
  localparam int          DEPTH = 512;
  localparam int          MAXO  = 4;
  localparam int          FB    = 1500;
  localparam logic [31:0] STEP  = 32'd64;

  logic        clk = 1'b0;
  logic        reset, enable, frame_start, fifo_pop, m_arready, r_last_done;
  logic [31:0] fb_base;
  logic        fifo_flush, m_arvalid, busy;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
`ifdef GSLCD_FETCH_DBUF_EN
  logic        swap_ack, swap_req;
  logic [31:0] fb_base_next;
`endif

  gslcd_fetch_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fb_base      (fb_base),
    .frame_start  (frame_start),
    .fifo_pop     (fifo_pop),
    .fifo_flush   (fifo_flush),
    .m_araddr     (m_araddr),
    .m_arlen      (m_arlen),
    .m_arvalid    (m_arvalid),
    .m_arready    (m_arready),
    .r_last_done  (r_last_done),
`ifdef GSLCD_FETCH_DBUF_EN
    .swap_ack     (swap_ack),
    .fb_base_next (fb_base_next),
    .swap_req     (swap_req),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  // Reference model
  int          m_credits, m_out;
  int          ar_count, frame_ars, flush_count, pops_seen;
  logic [31:0] exp_addr, last_hs_addr;
  bit          swap_pend_m;
  // AXI slave / stimulus knobs
  int          rsp_q[$];
  int          last_due;
  int          pop_mode;    // 0: pops_to_do only, 1: random, 2: every cycle
  int          pops_to_do;
  int          ready_mode;  // 0: low, 1: high, 2: random
  bit          rld_en;
  int          rld_manual, rld_force;
  bit          prev_valid;
  logic [31:0] prev_addr;

  function automatic logic [31:0] align64(input logic [31:0] a);
    return a - (a % STEP);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check/update the model from pre-edge values, advance, drive next inputs.
  task automatic cycle();
    bit          hs, rl_ok, pend_valid;
    logic [31:0] pend_addr;
    hs = (m_arvalid === 1'b1) && (m_arready === 1'b1);
    if (prev_valid) begin
      chk("ar_valid_held", m_arvalid, 1'b1);
      chk("ar_addr_held", m_araddr, prev_addr);
    end
    if (hs) begin
      chk("ar_addr", m_araddr, exp_addr);
      chk("ar_has_credit", (m_credits >= BL), 1'b1);
      chk("ar_under_cap", (m_out < MAXO), 1'b1);
      last_hs_addr = m_araddr;
      exp_addr     = exp_addr + STEP;
      ar_count++;
      frame_ars++;
      last_due = (last_due > cyc) ? last_due + $urandom_range(0, 3) : cyc + $urandom_range(1, 8);
      rsp_q.push_back(last_due);
    end
    if (fifo_flush === 1'b1) begin
      flush_count++;
      frame_ars = 0;
`ifdef GSLCD_FETCH_DBUF_EN
      chk("swap_ack_with_flush", swap_ack, swap_pend_m);
      exp_addr    = swap_pend_m ? align64(fb_base_next) : align64(fb_base);
      swap_pend_m = 1'b0;
`else
      exp_addr = align64(fb_base);
`endif
      m_credits = DEPTH;
    end else begin
      if (fifo_pop && m_credits < DEPTH) m_credits++;
      if (hs) m_credits -= BL;
    end
`ifdef GSLCD_FETCH_DBUF_EN
    if (swap_req) swap_pend_m = 1'b1;
`endif
    rl_ok = r_last_done && (m_out > 0);
    m_out = m_out + int'(hs) - int'(rl_ok);
    if (fifo_pop) pops_seen++;
    pend_valid = (m_arvalid === 1'b1) && (m_arready !== 1'b1);
    pend_addr  = m_araddr;

    @(posedge clk);
    #1;
    cyc++;
    prev_valid = pend_valid;
    prev_addr  = pend_addr;

    case (pop_mode)
      1:       fifo_pop = ($urandom_range(0, 3) != 0);
      2:       fifo_pop = 1'b1;
      default: begin
        fifo_pop = (pops_to_do > 0);
        if (pops_to_do > 0) pops_to_do--;
      end
    endcase
    case (ready_mode)
      0:       m_arready = 1'b0;
      1:       m_arready = 1'b1;
      default: m_arready = ($urandom_range(0, 1) == 1);
    endcase
    r_last_done = 1'b0;
    if (rld_force > 0) begin
      r_last_done = 1'b1;
      rld_force--;
    end else if (rld_manual > 0 && rsp_q.size() > 0) begin
      r_last_done = 1'b1;
      void'(rsp_q.pop_front());
      rld_manual--;
    end else if (rld_en && rsp_q.size() > 0) begin
      if (rsp_q[0] <= cyc) begin
        r_last_done = 1'b1;
        void'(rsp_q.pop_front());
      end
    end
`ifdef GSLCD_FETCH_DBUF_EN
    swap_req = 1'b0;
`endif
  endtask

  initial begin
    int base, tgt, lat;
    logic [31:0] held;

    reset = 1'b1; enable = 1'b0; frame_start = 1'b0; fifo_pop = 1'b0;
    m_arready = 1'b0; r_last_done = 1'b0; fb_base = 32'h0;
`ifdef GSLCD_FETCH_DBUF_EN
    swap_req = 1'b0; fb_base_next = 32'h0; swap_pend_m = 1'b0;
`endif
    m_credits = DEPTH; m_out = 0; ar_count = 0; frame_ars = 0; flush_count = 0;
    pops_seen = 0; exp_addr = 32'h0; last_hs_addr = 32'h0; last_due = 0;
    pop_mode = 0; pops_to_do = 0; ready_mode = 1; rld_en = 1'b1;
    rld_manual = 0; rld_force = 0; prev_valid = 1'b0; prev_addr = 32'h0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("reset_arvalid", m_arvalid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_flush", fifo_flush, 1'b0);
    chk("reset_araddr", m_araddr, 32'h0);
    chk("arlen", m_arlen, 8'd15);
    reset = 1'b0;
    m_arready = 1'b1;

    // Frame start: flush two cycles later, then 32 bursts and a credit stall
    enable = 1'b1; fb_base = 32'h1000_0000;
    repeat (3) cycle();
    chk("idle_busy", busy, 1'b0);
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    chk("drain_busy", busy, 1'b1);
    chk("no_flush_at_n1", fifo_flush, 1'b0);
    cycle();
    chk("flush_at_n2", fifo_flush, 1'b1);
    cycle();
    chk("flush_one_cycle", fifo_flush, 1'b0);
    chk("first_valid", m_arvalid, 1'b1);
    chk("first_addr", m_araddr, 32'h1000_0000);
    repeat (250) cycle();
    chk("bursts_until_stall", frame_ars, 32);
    chk("stall_no_valid", m_arvalid, 1'b0);

    // Credit refill: 16 pops allow exactly one more burst
    tgt = pops_seen + 16; pops_to_do = 16;
    for (int k = 0; k < 40 && pops_seen < tgt; k++) cycle();
    chk("refill_pops", pops_seen, tgt);
    lat = 0;
    while (m_arvalid !== 1'b1 && lat < 4) begin cycle(); lat++; end
    chk("refill_valid_within_2", (m_arvalid === 1'b1) && (lat <= 2), 1'b1);
    base = ar_count;
    repeat (30) cycle();
    chk("refill_single_ar", ar_count - base, 1);
    chk("refill_addr", last_hs_addr, 32'h1000_0800);

    // Outstanding cap with responses withheld
    for (int k = 0; k < 100 && (rsp_q.size() > 0 || m_out > 0); k++) cycle();
    rld_en = 1'b0; pop_mode = 2;
    base = ar_count;
    repeat (150) cycle();
    chk("cap_four_ars", ar_count - base, 4);
    chk("cap_no_valid", m_arvalid, 1'b0);
    rld_manual = 1;
    base = ar_count;
    repeat (20) cycle();
    chk("cap_one_more", ar_count - base, 1);
    rld_en = 1'b1;

    // Backpressure with a retrigger while the request is pending
    ready_mode = 0; m_arready = 1'b0;
    for (int k = 0; k < 100 && m_arvalid !== 1'b1; k++) cycle();
    chk("bp_valid_up", m_arvalid, 1'b1);
    held = m_araddr;
    chk("bp_addr_expected", held, exp_addr);
    fb_base = 32'h3000_0024;
    for (int i = 0; i < 10; i++) begin
      frame_start = (i == 3);
      cycle();
      frame_start = 1'b0;
      chk("bp_valid_stable", m_arvalid, 1'b1);
      chk("bp_addr_stable", m_araddr, held);
    end
    ready_mode = 1; m_arready = 1'b1;
    base = ar_count;
    cycle();
    chk("bp_handshake", ar_count - base, 1);
    for (int k = 0; k < 200 && fifo_flush !== 1'b1; k++) cycle();
    chk("retrig_flush", fifo_flush, 1'b1);
    chk("retrig_no_ar_in_drain", ar_count - base, 1);
    // Pops right after flush must saturate at FIFO depth
    ready_mode = 0; m_arready = 1'b0; pop_mode = 0; pops_to_do = 20;
    repeat (25) cycle();
    chk("restart_valid", m_arvalid, 1'b1);
    chk("restart_addr", m_araddr, 32'h3000_0000);
    ready_mode = 1; m_arready = 1'b1;
    base = ar_count;
    repeat (250) cycle();
    chk("saturated_32", ar_count - base, 32);

    // Run the frame to its end: exactly FRAME_BURSTS bursts, then idle
    pop_mode = 2; ready_mode = 2;
    for (int k = 0; k < 40000 && busy === 1'b1; k++) cycle();
    chk("frame_end_idle", busy, 1'b0);
    chk("frame_total", frame_ars, FB);
    chk("frame_end_no_valid", m_arvalid, 1'b0);
    pop_mode = 0; ready_mode = 1;
    repeat (20) cycle();

    // enable=0 at frame_start: drain and return to idle, no flush, no AR
    base = ar_count; tgt = flush_count;
    enable = 1'b0; frame_start = 1'b1; cycle(); frame_start = 1'b0; enable = 1'b1;
    chk("disabled_busy", busy, 1'b1);
    for (int k = 0; k < 20 && busy === 1'b1; k++) cycle();
    chk("disabled_idle", busy, 1'b0);
    chk("disabled_no_flush", flush_count - tgt, 0);
    chk("disabled_no_ar", ar_count - base, 0);

    // Spurious r_last_done with nothing outstanding is ignored
    rld_force = 2;
    repeat (4) cycle();
    fb_base = 32'h0400_0000;
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    cycle();
    chk("spurious_rld_flush_n2", fifo_flush, 1'b1);
    pop_mode = 2;
    repeat (40) cycle();

`ifdef GSLCD_FETCH_DBUF_EN
    // Buffer swap requested mid-frame takes effect at the next flush
    fb_base_next = 32'h2000_0000;
    swap_req = 1'b1; cycle();
    repeat (30) cycle();
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    for (int k = 0; k < 100 && fifo_flush !== 1'b1; k++) cycle();
    chk("dbuf_flush", fifo_flush, 1'b1);
    chk("dbuf_swap_ack", swap_ack, 1'b1);
    base = ar_count;
    for (int k = 0; k < 50 && ar_count == base; k++) cycle();
    chk("dbuf_first_addr", last_hs_addr, 32'h2000_0000);
`endif

    // Randomized traffic with occasional retriggers
    pop_mode = 1; ready_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        frame_start = 1'b1;
        enable      = ($urandom_range(0, 3) != 0);
        fb_base     = $urandom;
      end
      cycle();
      frame_start = 1'b0;
    end
    chk("random_ars_seen", (ar_count > 1600), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
